// File: rtl/trigger_capture_seq_if.sv
// Memory write port between the capture sequencer (master) and the DMA/BRAM writer (slave).
interface trigger_capture_seq_if #(
    parameter int unsigned DATA_W = 28,
    parameter int unsigned ADDR_W = 32
);
    logic [DATA_W-1:0] data_out;
    logic              write_enable;
    logic [ADDR_W-1:0] write_address;

    modport master (
        output data_out,
        output write_enable,
        output write_address
    );

    modport slave (
        input data_out,
        input write_enable,
        input write_address
    );
endinterface

// File: rtl/trigger_capture_seq.sv
// Trigger-armed multi-channel capture sequencer streaming ADC words to a memory write port.
// Define TRIGSEQ_MISS_CNT_EN to build the saturating trigger-miss counter and its port.
module trigger_capture_seq #(
    parameter int unsigned ADC_W      = 14,
    parameter int unsigned N_CH       = 2,
    parameter int unsigned CNT_W      = 25,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned ADDR_STEP  = 4,
    parameter int unsigned TRIG_DELAY = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*ADC_W-1:0]    adc_data_i,
    input  logic                     trig_i,
    input  logic                     arm_i,
    input  logic                     abort_i,
    input  logic [CNT_W-1:0]         num_samples_i,
    input  logic [CNT_W-1:0]         num_reps_i,
    input  logic [ADDR_W-1:0]        base_addr_i,
    trigger_capture_seq_if.master    wr_if,
    output logic                     busy_o,
    output logic                     done_o
`ifdef TRIGSEQ_MISS_CNT_EN
    ,
    output logic [15:0]              trig_miss_cnt_o
`endif
);

    localparam int unsigned DataW = N_CH * ADC_W;
    localparam int unsigned DlyW  = (TRIG_DELAY > 1) ? $clog2(TRIG_DELAY) : 1;

    typedef enum logic [1:0] {StIdle, StArmed, StDelay, StCapture} state_e;

    state_e             state_q, state_d;
    logic [DataW-1:0]   data_q, data_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               done_q, done_d;
    logic               last_trig_q;
    logic [CNT_W-1:0]   smp_cfg_q, smp_cfg_d;
    logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
    logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic [DlyW-1:0]    dly_cnt_q, dly_cnt_d;
    logic               trig_edge;
    logic               issue_write;

    assign trig_edge = trig_i & ~last_trig_q;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        done_d      = 1'b0;
        smp_cfg_d   = smp_cfg_q;
        smp_cnt_d   = smp_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        dly_cnt_d   = dly_cnt_q;
        issue_write = 1'b0;

        // Address runs on across repetitions; only arm reloads it.
        if (we_q) begin
            addr_d = addr_q + ADDR_W'(ADDR_STEP);
        end

        unique case (state_q)
            StIdle: begin
                if (arm_i) begin
                    state_d   = StArmed;
                    smp_cfg_d = num_samples_i;
                    rep_cnt_d = num_reps_i;
                    addr_d    = base_addr_i;
                end
            end
            StArmed: begin
                if (rep_cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (trig_edge) begin
                    state_d   = StDelay;
                    dly_cnt_d = DlyW'(TRIG_DELAY - 1);
                end
            end
            StDelay: begin
                if (dly_cnt_q == '0) begin
                    state_d     = StCapture;
                    issue_write = 1'b1;
                    smp_cnt_d   = smp_cfg_q;
                end else begin
                    dly_cnt_d = dly_cnt_q - DlyW'(1);
                end
            end
            StCapture: begin
                if (smp_cnt_q != '0) begin
                    issue_write = 1'b1;
                    smp_cnt_d   = smp_cnt_q - CNT_W'(1);
                end else begin
                    rep_cnt_d = rep_cnt_q - CNT_W'(1);
                    if (rep_cnt_q == CNT_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StArmed;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (issue_write) begin
            we_d   = 1'b1;
            data_d = adc_data_i;
        end

        if (abort_i) begin
            state_d   = StIdle;
            we_d      = 1'b0;
            done_d    = 1'b0;
            data_d    = data_q;
            smp_cfg_d = '0;
            smp_cnt_d = '0;
            rep_cnt_d = '0;
            dly_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            data_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            done_q      <= 1'b0;
            last_trig_q <= 1'b1;
            smp_cfg_q   <= '0;
            smp_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            dly_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
            last_trig_q <= trig_i;
            smp_cfg_q   <= smp_cfg_d;
            smp_cnt_q   <= smp_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            dly_cnt_q   <= dly_cnt_d;
        end
    end

    assign wr_if.data_out      = data_q;
    assign wr_if.write_enable  = we_q;
    assign wr_if.write_address = addr_q;
    assign busy_o              = (state_q != StIdle);
    assign done_o              = done_q;

`ifdef TRIGSEQ_MISS_CNT_EN
    logic [15:0] miss_q, miss_d;

    // Edges seen while delaying or capturing are dropped, so count them here.
    always_comb begin
        miss_d = miss_q;
        if (state_q == StIdle && arm_i && !abort_i) begin
            miss_d = '0;
        end else if (trig_edge && (state_q == StDelay || state_q == StCapture) &&
                     miss_q != 16'hFFFF) begin
            miss_d = miss_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign trig_miss_cnt_o = miss_q;
`endif

endmodule

// File: tb/tb_trigger_capture_seq.sv
// Self-checking bench for trigger_capture_seq: window-based reference model plus directed cases.
module tb_trigger_capture_seq;

    localparam int TD  = 6;
    localparam int INF = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] adc;
    logic        trig;
    logic        arm;
    logic        abort;
    logic [24:0] ns_in;
    logic [24:0] reps_in;
    logic [31:0] base_in;
    logic        busy;
    logic        done;
`ifdef TRIGSEQ_MISS_CNT_EN
    logic [15:0] miss;
`endif

    trigger_capture_seq_if #(.DATA_W(28), .ADDR_W(32)) wr_if ();

    trigger_capture_seq dut (
        .clk           (clk),
        .rst           (rst),
        .adc_data_i    (adc),
        .trig_i        (trig),
        .arm_i         (arm),
        .abort_i       (abort),
        .num_samples_i (ns_in),
        .num_reps_i    (reps_in),
        .base_addr_i   (base_in),
        .wr_if         (wr_if),
        .busy_o        (busy),
        .done_o        (done)
`ifdef TRIGSEQ_MISS_CNT_EN
        ,
        .trig_miss_cnt_o(miss)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit adc_count_mode = 1'b1;
    int adc_cv;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // adc value driven here is the one sampled at edge cyc+1; in count mode it equals that index.
    initial forever begin
        @(posedge clk);
        #1;
        if (adc_count_mode) begin
            adc_cv = cyc + 1;
            adc = {14'(adc_cv + 256), 14'(adc_cv)};
        end else begin
            adc = 28'($urandom);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed write stream and done pulses, recorded from the DUT.
    logic [31:0] q_addr[$];
    logic [27:0] q_data[$];
    int          q_edge[$];
    int          done_cnt  = 0;
    int          done_edge = -1;

    // Reference model: a run is a set of time windows derived from each accepted trigger edge.
    bit          m_run = 1'b0;
    int          m_done_at, m_listen, m_ws, m_we_end, m_reps, m_miss_from, m_miss_to;
    logic [24:0] m_ns;
    logic [31:0] m_addr;
    logic        m_prev_trig = 1'b1;
    bit          x_we = 1'b0, x_done = 1'b0, x_busy = 1'b0;
    logic [27:0] x_data;
    logic [31:0] x_addr;
    logic [15:0] x_miss = '0;

    always @(negedge clk) begin : model
        int e;
        bit es;
        if (rst) begin
            chk("rst_we", 64'(wr_if.write_enable), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_done", 64'(done), 64'(0));
            chk("rst_data", 64'(wr_if.data_out), 64'(0));
            chk("rst_addr", 64'(wr_if.write_address), 64'(0));
            m_run = 1'b0; m_prev_trig = 1'b1;
            x_we = 1'b0; x_done = 1'b0; x_busy = 1'b0; x_miss = '0;
        end else begin
            chk("we", 64'(wr_if.write_enable), 64'(x_we));
            chk("done", 64'(done), 64'(x_done));
            chk("busy", 64'(busy), 64'(x_busy));
            if (x_we) begin
                chk("data", 64'(wr_if.data_out), 64'(x_data));
                chk("addr", 64'(wr_if.write_address), 64'(x_addr));
            end
`ifdef TRIGSEQ_MISS_CNT_EN
            chk("miss_cnt", 64'(miss), 64'(x_miss));
`endif
            if (wr_if.write_enable) begin
                q_addr.push_back(wr_if.write_address);
                q_data.push_back(wr_if.data_out);
                q_edge.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_edge = cyc;
            end
            // Predict the outputs following the next edge from the inputs now stable.
            e  = cyc + 1;
            es = trig && !m_prev_trig;
            if (m_run && es && e >= m_miss_from && e <= m_miss_to && x_miss != 16'hFFFF)
                x_miss = x_miss + 16'd1;
            x_we = 1'b0;
            x_done = 1'b0;
            if (abort) begin
                m_run = 1'b0;
            end else if (!m_run) begin
                if (arm) begin
                    m_run = 1'b1; m_ns = ns_in; m_reps = int'(reps_in); m_addr = base_in;
                    m_ws = INF; m_we_end = -1; m_miss_from = INF; m_miss_to = -1;
                    x_miss = '0;
                    if (m_reps == 0) begin
                        m_done_at = e + 1; m_listen = INF;
                    end else begin
                        m_done_at = INF; m_listen = e + 1;
                    end
                end
            end else begin
                if (e == m_done_at) begin
                    x_done = 1'b1;
                    m_run = 1'b0;
                end else if (e >= m_listen && es) begin
                    m_ws = e + TD;
                    m_we_end = m_ws + int'(m_ns);
                    m_miss_from = e + 1;
                    m_miss_to = m_we_end + 1;
                    m_reps--;
                    if (m_reps == 0) begin
                        m_done_at = m_we_end + 1; m_listen = INF;
                    end else begin
                        m_listen = m_we_end + 2;
                    end
                end
                if (m_run && e >= m_ws && e <= m_we_end) begin
                    x_we = 1'b1;
                    x_data = adc;
                    x_addr = m_addr;
                    m_addr = m_addr + 32'd4;
                end
            end
            x_busy = m_run;
            m_prev_trig = trig;
        end
    end

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_edge.delete();
    endtask

    // Arm, then scramble the config inputs so only latched values can matter.
    task automatic do_arm(input logic [31:0] b, input logic [24:0] n, input logic [24:0] r);
        base_in = b; ns_in = n; reps_in = r; arm = 1'b1;
        tick();
        arm = 1'b0;
        base_in = $urandom;
        ns_in = 25'($urandom_range(0, 7));
        reps_in = 25'($urandom_range(0, 3));
    endtask

    task automatic trig_pulse(output int t);
        trig = 1'b1;
        tick();
        t = cyc;
        trig = 1'b0;
    endtask

    initial begin
        int t1, t2, k, cnt, d0;
        trig = 1'b0; arm = 1'b0; abort = 1'b0;
        ns_in = '0; reps_in = '0; base_in = '0; adc = '0;
        #1;
        chk("init_we", 64'(wr_if.write_enable), 64'(0));
        chk("init_busy", 64'(busy), 64'(0));
        chk("init_addr", 64'(wr_if.write_address), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Normal run: two reps of four words at 0x1000.
        clear_log();
        d0 = done_cnt;
        do_arm(32'h1000, 25'd3, 25'd2);
        tick();
        trig_pulse(t1);
        repeat (12) tick();
        trig_pulse(t2);
        repeat (12) tick();
        chk("norm_nwrites", 64'(q_addr.size()), 64'(8));
        if (q_addr.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("norm_addr", 64'(q_addr[i]), 64'(32'h1000 + 4 * i));
            chk("norm_lat1", 64'(q_edge[0] - t1), 64'(6));
            chk("norm_lat2", 64'(q_edge[4] - t2), 64'(6));
            chk("norm_burst", 64'(q_edge[3] - q_edge[0]), 64'(3));
            chk("align_ch0", 64'(q_data[0][13:0]), 64'(14'(t1 + 6)));
            chk("align_ch1", 64'(q_data[0][27:14]), 64'(14'(t1 + 6 + 256)));
        end
        chk("norm_done", 64'(done_cnt - d0), 64'(1));
        chk("norm_busy_end", 64'(busy), 64'(0));

        // Abort on word 2 of 4, then re-arm restarts at base.
        adc_count_mode = 1'b0;
        d0 = done_cnt;
        do_arm(32'h2000, 25'd3, 25'd1);
        trig_pulse(t1);
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 2; i++) begin
            tick();
            if (wr_if.write_enable) cnt++;
        end
        chk("abort_reach", 64'(cnt), 64'(2));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_we", 64'(wr_if.write_enable), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        tick();
        chk("abort_nodone", 64'(done_cnt - d0), 64'(0));
        clear_log();
        do_arm(32'h2000, 25'd0, 25'd1);
        trig_pulse(t1);
        repeat (10) tick();
        chk("rearm_n", 64'(q_addr.size()), 64'(1));
        if (q_addr.size() == 1) chk("rearm_addr", 64'(q_addr[0]), 64'(32'h2000));

        // Extra trigger edge during CAPTURE is ignored.
        clear_log();
        do_arm(32'h4000, 25'd3, 25'd1);
        trig_pulse(t1);
        repeat (7) tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (10) tick();
        chk("retrig_n", 64'(q_addr.size()), 64'(4));
`ifdef TRIGSEQ_MISS_CNT_EN
        chk("retrig_miss", 64'(miss), 64'(1));
`endif

        // Address wrap at the top of the space.
        clear_log();
        do_arm(32'hFFFF_FFF8, 25'd3, 25'd1);
        trig_pulse(t1);
        repeat (12) tick();
        chk("wrap_n", 64'(q_addr.size()), 64'(4));
        if (q_addr.size() == 4) begin
            chk("wrap_a0", 64'(q_addr[0]), 64'(32'hFFFF_FFF8));
            chk("wrap_a1", 64'(q_addr[1]), 64'(32'hFFFF_FFFC));
            chk("wrap_a2", 64'(q_addr[2]), 64'(32'h0000_0000));
            chk("wrap_a3", 64'(q_addr[3]), 64'(32'h0000_0004));
        end

        // num_reps = 0: done two cycles after arm, nothing written.
        clear_log();
        d0 = done_cnt;
        k = cyc;
        do_arm(32'h5000, 25'd2, 25'd0);
        repeat (4) tick();
        chk("zero_done_cnt", 64'(done_cnt - d0), 64'(1));
        chk("zero_done_lat", 64'(done_edge - k), 64'(2));
        chk("zero_writes", 64'(q_addr.size()), 64'(0));

        // Async reset in DELAY; trig held high through release must not capture.
        clear_log();
        do_arm(32'h6000, 25'd3, 25'd1);
        trig_pulse(t1);
        tick();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we", 64'(wr_if.write_enable), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        chk("arst_data", 64'(wr_if.data_out), 64'(0));
        chk("arst_addr", 64'(wr_if.write_address), 64'(0));
        trig = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        do_arm(32'h7000, 25'd1, 25'd1);
        repeat (15) tick();
        chk("held_nowrite", 64'(q_addr.size()), 64'(0));
        chk("held_busy", 64'(busy), 64'(1));
        trig = 1'b0;
        tick();
        trig_pulse(t1);
        repeat (10) tick();
        chk("fresh_n", 64'(q_addr.size()), 64'(2));
        if (q_addr.size() == 2) chk("fresh_addr", 64'(q_addr[0]), 64'(32'h7000));

        // Randomised runs checked cycle by cycle against the model.
        for (int r = 0; r < 30; r++) begin
            do_arm($urandom, 25'($urandom_range(0, 4)), 25'($urandom_range(0, 3)));
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 3) == 0) trig = ~trig;
                abort = ($urandom_range(0, 99) == 0);
                arm = ($urandom_range(0, 39) == 0);
                ns_in = 25'($urandom_range(0, 4));
                reps_in = 25'($urandom_range(0, 3));
                base_in = $urandom;
                tick();
            end
            arm = 1'b0;
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
